// File: rtl/player_motion_controller_pkg.sv
// Shared encodings, screen bounds and physics constants for the player sprite motion block.
// step_x applies one tick of horizontal walking with clamping to the visible area.
package player_motion_controller_pkg;

  localparam logic [3:0]        PLAY_STATE = 4'd2;

  localparam logic [9:0]        SPAWN_X    = 10'd200;
  localparam logic [9:0]        GROUND_Y   = 10'd450;
  localparam logic [9:0]        X_MIN      = 10'd144;
  localparam logic [9:0]        X_MAX      = 10'd783;
  localparam logic [9:0]        Y_MIN      = 10'd35;
  localparam logic [9:0]        WALK_STEP  = 10'd2;

  localparam logic signed [3:0] JUMP_V     = -4'sd7;
  localparam logic signed [3:0] MAX_FALL   = 4'sd7;
  localparam logic signed [5:0] GRAVITY    = 6'sd1;
  localparam logic signed [5:0] GRAVITY_DN = 6'sd2;

  localparam int                FRAME_DIV  = 4;
  localparam int                NUM_FRAMES = 8;

  typedef enum logic [1:0] {
    POSE_IDLE  = 2'd0,
    POSE_RIGHT = 2'd1,
    POSE_LEFT  = 2'd2,
    POSE_JUMP  = 2'd3
  } pose_t;

  typedef enum logic {
    ST_GROUNDED = 1'b0,
    ST_AIRBORNE = 1'b1
  } motion_state_t;

  function automatic logic [9:0] step_x(input logic [9:0] x,
                                        input logic       go_left,
                                        input logic       go_right);
    logic [10:0] inc;
    inc = {1'b0, x} + {1'b0, WALK_STEP};
    if (go_right && !go_left)
      step_x = (inc > {1'b0, X_MAX}) ? X_MAX : inc[9:0];
    else if (go_left && !go_right)
      step_x = (x < X_MIN + WALK_STEP) ? X_MIN : x - WALK_STEP;
    else
      step_x = x;
  endfunction

endpackage

// File: rtl/player_motion_controller_anim_frame_counter.sv
// Walk-cycle frame counter: advances the frame once every FRAME_DIV enabled ticks, wrapping
// after NUM_FRAMES-1. The divider is a down-counter reloaded on terminal count or clear.
module player_motion_controller_anim_frame_counter #(
  parameter int FRAME_DIV  = 4,
  parameter int NUM_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       enable,
  input  logic       clear,
  output logic [6:0] frame
);

  localparam int              DW         = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LOAD   = DW'(FRAME_DIV - 1);
  localparam logic [6:0]      LAST_FRAME = 7'(NUM_FRAMES - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= DIV_LOAD;
      frame   <= '0;
    end else if (tick) begin
      if (clear) begin
        div_cnt <= DIV_LOAD;
        frame   <= '0;
      end else if (enable) begin
        if (div_cnt == '0) begin
          div_cnt <= DIV_LOAD;
          frame   <= (frame == LAST_FRAME) ? '0 : frame + 7'd1;
        end else begin
          div_cnt <= div_cnt - DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/player_motion_controller.sv
// Per-tick player sprite sequencing: walking, jump/gravity physics and walk animation.
// state       | meaning
// ST_GROUNDED | standing or walking on the floor; an up edge launches a jump
// ST_AIRBORNE | rising or falling; integrates y_speed, lands at GROUND_Y
module player_motion_controller
  import player_motion_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] curr_state,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [1:0] pose,
  output logic [6:0] animation_frame_num,
  output logic       airborne
);

  motion_state_t     state, state_nxt;
  logic signed [3:0] y_speed, spd_nxt;
  logic [9:0]        x_nxt, y_nxt;
  logic              up_q;
  pose_t             pose_q, pose_nxt;
  logic              in_play, walking, up_edge;
  logic              anim_en, anim_clr;
  logic signed [10:0] y_sum;
  logic signed [5:0]  spd_sum;

  assign in_play = (curr_state == PLAY_STATE);
  assign walking = left ^ right;
  assign up_edge = up & ~up_q;
  assign y_sum   = $signed({1'b0, ypos}) + $signed({{7{y_speed[3]}}, y_speed});
  assign spd_sum = $signed({{2{y_speed[3]}}, y_speed}) + (down ? GRAVITY_DN : GRAVITY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_GROUNDED;
      xpos    <= SPAWN_X;
      ypos    <= GROUND_Y;
      y_speed <= '0;
      pose_q  <= POSE_IDLE;
      up_q    <= 1'b0;
    end else if (tick) begin
      state   <= state_nxt;
      xpos    <= x_nxt;
      ypos    <= y_nxt;
      y_speed <= spd_nxt;
      pose_q  <= pose_nxt;
      up_q    <= up;
    end
  end

  always_comb begin
    state_nxt = state;
    y_nxt     = ypos;
    spd_nxt   = y_speed;
    x_nxt     = step_x(xpos, left, right);
    if (!in_play) begin
      state_nxt = ST_GROUNDED;
      y_nxt     = GROUND_Y;
      spd_nxt   = '0;
      x_nxt     = SPAWN_X;
    end else begin
      case (state)
        ST_GROUNDED: begin
          if (up_edge) begin
            spd_nxt   = JUMP_V;
            state_nxt = ST_AIRBORNE;
          end
        end
        ST_AIRBORNE: begin
          if (y_sum >= $signed({1'b0, GROUND_Y})) begin
            y_nxt     = GROUND_Y;
            spd_nxt   = '0;
            state_nxt = ST_GROUNDED;
          end else if (y_sum < $signed({1'b0, Y_MIN})) begin
            // Head bump: pin to the ceiling and restart the fall from rest.
            y_nxt   = Y_MIN;
            spd_nxt = '0;
          end else begin
            y_nxt   = y_sum[9:0];
            spd_nxt = (spd_sum > $signed({2'b00, MAX_FALL})) ? MAX_FALL : spd_sum[3:0];
          end
        end
      endcase
    end
  end

  // Pose and animation follow the post-update state, so the launch tick already shows JUMP.
  always_comb begin
    pose_nxt = POSE_IDLE;
    anim_en  = 1'b0;
    anim_clr = 1'b0;
    if (!in_play) begin
      anim_clr = 1'b1;
    end else if (state_nxt == ST_AIRBORNE) begin
      pose_nxt = POSE_JUMP;
    end else if (walking) begin
      anim_en  = 1'b1;
      pose_nxt = right ? POSE_RIGHT : POSE_LEFT;
    end else begin
      anim_clr = 1'b1;
    end
  end

  assign pose     = pose_q;
  assign airborne = (state == ST_AIRBORNE);

  player_motion_controller_anim_frame_counter #(
    .FRAME_DIV  (FRAME_DIV),
    .NUM_FRAMES (NUM_FRAMES)
  ) u_anim (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .enable (anim_en),
    .clear  (anim_clr),
    .frame  (animation_frame_num)
  );

endmodule

// File: tb/tb_player_motion_controller.sv
// Scoreboard bench for player_motion_controller: the driver pushes model results per tick,
// the monitor pops on every ticked edge and also checks that nothing moves between ticks.
module tb_player_motion_controller;

  typedef struct {
    int x;
    int y;
    int pose;
    int frame;
    int air;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] curr_state = 4'd0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [9:0] xpos, ypos;
  logic [1:0] pose;
  logic [6:0] animation_frame_num;
  logic       airborne;

  exp_t exp_q[$];
  bit   done = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state: plain integers straight from the motion rules.
  int m_x, m_y, m_v, m_air, m_upq, m_walk, m_frame, m_pose;

  player_motion_controller dut (
    .clk                 (clk),
    .rst                 (rst),
    .tick                (tick),
    .curr_state          (curr_state),
    .up                  (up),
    .down                (down),
    .left                (left),
    .right               (right),
    .xpos                (xpos),
    .ypos                (ypos),
    .pose                (pose),
    .animation_frame_num (animation_frame_num),
    .airborne            (airborne)
  );

  always #5 clk = ~clk;

  function automatic exp_t reset_exp();
    exp_t e;
    e.x = 200; e.y = 450; e.pose = 0; e.frame = 0; e.air = 0;
    return e;
  endfunction

  task automatic model_reset();
    m_x = 200; m_y = 450; m_v = 0; m_air = 0; m_upq = 0;
    m_walk = 0; m_frame = 0; m_pose = 0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit u, input bit d, input int cs);
    int s;
    if (cs != 2) begin
      model_reset();
      m_upq = u;
    end else begin
      if (m_air == 0) begin
        if (u && !m_upq) begin
          m_v = -7;
          m_air = 1;
        end
      end else begin
        s = m_y + m_v;
        if (s >= 450) begin
          m_y = 450; m_v = 0; m_air = 0;
        end else if (s < 35) begin
          m_y = 35; m_v = 0;
        end else begin
          m_y = s;
          m_v = m_v + (d ? 2 : 1);
          if (m_v > 7) m_v = 7;
        end
      end
      m_upq = u;
      if (r && !l)      m_x = (m_x + 2 > 783) ? 783 : m_x + 2;
      else if (l && !r) m_x = (m_x - 2 < 144) ? 144 : m_x - 2;
      if (m_air != 0)   m_pose = 3;
      else if (r && !l) m_pose = 1;
      else if (l && !r) m_pose = 2;
      else              m_pose = 0;
      if (m_air == 0) begin
        if (l != r) begin
          m_walk++;
          if (m_walk == 4) begin
            m_walk = 0;
            m_frame = (m_frame + 1) % 8;
          end
        end else begin
          m_walk = 0;
          m_frame = 0;
        end
      end
    end
  endtask

  task automatic step(input bit l, input bit r, input bit u, input bit d, input int cs,
                      input int gap);
    exp_t e;
    @(negedge clk);
    left = l; right = r; up = u; down = d; curr_state = 4'(cs); tick = 1'b1;
    model_tick(l, r, u, d, cs);
    e.x = m_x; e.y = m_y; e.pose = m_pose; e.frame = m_frame; e.air = m_air;
    exp_q.push_back(e);
    @(negedge clk);
    tick = 1'b0;
    for (int g = 0; g < gap; g++) begin
      left = 1'($urandom); right = 1'($urandom); up = 1'($urandom); down = 1'($urandom);
      curr_state = 4'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    tick = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  // Monitor: compares on every rising edge (ticked or not) and right after reset asserts.
  initial begin : monitor
    exp_t cur;
    logic t;
    cur = reset_exp();
    while (!done) begin
      @(posedge clk or negedge rst);
      t = tick;
      #1;
      if (!rst) begin
        cur = reset_exp();
        exp_q.delete();
      end else if (t) begin
        if (exp_q.size() == 0) chk("queue_underflow", 1, 0);
        else cur = exp_q.pop_front();
      end
      chk("xpos", int'(xpos), cur.x);
      chk("ypos", int'(ypos), cur.y);
      chk("pose", int'(pose), cur.pose);
      chk("frame", int'(animation_frame_num), cur.frame);
      chk("airborne", int'(airborne), cur.air);
    end
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin : driver
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Jump with up held throughout: one launch, full arc, no re-jump.
    step(0, 0, 1, 0, 2, 0);
    repeat (17) step(0, 0, 1, 0, 2, 1);
    step(0, 0, 0, 0, 2, 0);

    // Walk right nine ticks, then release.
    repeat (9) step(0, 1, 0, 0, 2, 0);
    step(0, 0, 0, 0, 2, 0);

    // Right wall, both buttons, left wall.
    repeat (300) step(0, 1, 0, 0, 2, 0);
    step(1, 1, 0, 0, 2, 1);
    repeat (330) step(1, 0, 0, 0, 2, 0);
    step(1, 1, 0, 0, 2, 0);

    // Jump to apex, then fall with down held.
    step(0, 0, 1, 0, 2, 0);
    repeat (7) step(0, 0, 0, 0, 2, 0);
    repeat (9) step(0, 0, 0, 1, 2, 0);

    // Leave play mid-jump, idle cycles with random inputs, then return.
    step(0, 1, 1, 0, 2, 0);
    repeat (3) step(0, 1, 0, 0, 2, 0);
    step(0, 1, 0, 0, 0, 4);
    step(0, 0, 1, 0, 5, 2);
    step(0, 0, 1, 0, 2, 0);

    // Asynchronous reset in the middle of a jump.
    step(0, 0, 0, 0, 2, 0);
    step(1, 0, 1, 0, 2, 0);
    repeat (3) step(1, 0, 0, 0, 2, 0);
    async_reset();
    step(0, 1, 0, 0, 2, 0);

    // Randomized play.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15)) : 2,
           int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

endmodule
